umi_pkt_switch: RTL and testbench

UMI_PKT_SWITCH -- requirements
Module: umi_pkt_switch

---
 rtl/umi_pkt_switch_if.sv | 43 ++++
 rtl/umi_pkt_switch.sv | 181 ++++++++++++++++++
 tb/tb_umi_pkt_switch.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/umi_pkt_switch_if.sv
// UMI packet switch bus bundle.
// Carries the per-input request/payload/ready signals and the per-output
// valid/payload/ready/lock signals of umi_pkt_switch.
//   slave  : switch side (consumes umi_in_*, drives umi_out_* and umi_in_ready)
//   master : environment side (drives umi_in_*, consumes umi_out_*)
interface umi_pkt_switch_if #(
  parameter int N  = 4,
  parameter int M  = 4,
  parameter int DW = 128,
  parameter int CW = 32,
  parameter int AW = 64
);
  logic [N*M-1:0]  umi_in_valid;
  logic [N*CW-1:0] umi_in_cmd;
  logic [N*AW-1:0] umi_in_dstaddr;
  logic [N*AW-1:0] umi_in_srcaddr;
  logic [N*DW-1:0] umi_in_data;
  logic [N-1:0]    umi_in_ready;

  logic [M-1:0]    umi_out_valid;
  logic [M*CW-1:0] umi_out_cmd;
  logic [M*AW-1:0] umi_out_dstaddr;
  logic [M*AW-1:0] umi_out_srcaddr;
  logic [M*DW-1:0] umi_out_data;
  logic [M-1:0]    umi_out_ready;
  logic [M-1:0]    umi_out_lock;

  modport slave (
    input  umi_in_valid, umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data,
    output umi_in_ready,
    output umi_out_valid, umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data,
    output umi_out_lock,
    input  umi_out_ready
  );

  modport master (
    output umi_in_valid, umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data,
    input  umi_in_ready,
    input  umi_out_valid, umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data,
    input  umi_out_lock,
    output umi_out_ready
  );
endinterface

// File: rtl/umi_pkt_switch.sv
// UMI N-input x M-output packet switch.
// Each output owns an arbiter (fixed priority or round-robin), a packet lock
// that keeps multi-beat messages contiguous, and a DEPTH-entry FIFO.
// Ports:
//   clk      - single clock, rising edge
//   reset    - asynchronous, active-high
//   arbmode  - 0 fixed priority (lowest input wins), otherwise round-robin
//   arbmask  - dynamic request mask, bit i*N+j = 1 blocks input j -> output i
//   umi      - bus bundle (slave modport): inputs, outputs, ready, lock
module umi_pkt_switch #(
  parameter int             N      = 4,
  parameter int             M      = 4,
  parameter logic [M*N-1:0] MASK   = '0,
  parameter int             DW     = 128,
  parameter int             CW     = 32,
  parameter int             AW     = 64,
  parameter int             DEPTH  = 4,
  parameter int             EOMBIT = 22
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      arbmode,
  input  logic [N*M-1:0]  arbmask,
  umi_pkt_switch_if.slave umi
);
  localparam int PW   = CW + 2*AW + DW;
  localparam int IW   = (N > 1) ? $clog2(N) : 1;
  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;

  logic [PW-1:0]   in_pkt [N];
  logic [N*M-1:0]  req_eff;
  logic [N-1:0]    claimed;
  logic [N-1:0]    req [M];
  logic [M-1:0]    found;
  logic [IW-1:0]   src [M];
  logic [M-1:0]    full, push, pop, eom;
  logic [PW-1:0]   head [M];

  logic [CNTW-1:0] count_q [M], count_d [M];
  logic [PTRW-1:0] wr_ptr_q [M], wr_ptr_d [M];
  logic [PTRW-1:0] rd_ptr_q [M], rd_ptr_d [M];
  logic [M-1:0]    lock_q, lock_d;
  logic [IW-1:0]   lock_src_q [M], lock_src_d [M];
  logic [IW-1:0]   rr_q [M], rr_d [M];
  logic [PW-1:0]   mem_q [M][DEPTH], mem_d [M][DEPTH];

  // Entry layout: {cmd, dstaddr, srcaddr, data}
  always_comb begin
    for (int j = 0; j < N; j++) begin
      in_pkt[j] = {umi.umi_in_cmd[j*CW +: CW], umi.umi_in_dstaddr[j*AW +: AW],
                   umi.umi_in_srcaddr[j*AW +: AW], umi.umi_in_data[j*DW +: DW]};
    end
  end

  // An input asserting several outputs is only seen by the lowest one.
  always_comb begin
    req_eff = umi.umi_in_valid & ~MASK & ~arbmask;
    claimed = '0;
    for (int i = 0; i < M; i++) begin
      req[i] = '0;
      for (int j = 0; j < N; j++) begin
        if (req_eff[i*N+j] && !claimed[j]) begin
          req[i][j]  = 1'b1;
          claimed[j] = 1'b1;
        end
      end
    end
  end

  // Per-output arbitration. Loops run from lowest to highest priority so
  // the last match is the winner.
  always_comb begin : arb_p
    logic [IW-1:0] cand;
    cand = '0;
    for (int i = 0; i < M; i++) begin
      found[i] = 1'b0;
      src[i]   = '0;
      if (lock_q[i]) begin
        // A locked output waits for its owner even if the owner is masked.
        found[i] = req[i][lock_src_q[i]];
        src[i]   = lock_src_q[i];
      end else if (arbmode == 2'd0) begin
        for (int j = N-1; j >= 0; j--) begin
          cand = IW'(j);
          if (req[i][cand]) begin
            found[i] = 1'b1;
            src[i]   = cand;
          end
        end
      end else begin
        for (int k = N; k >= 1; k--) begin
          cand = IW'((int'(rr_q[i]) + k) % N);
          if (req[i][cand]) begin
            found[i] = 1'b1;
            src[i]   = cand;
          end
        end
      end
      eom[i]  = in_pkt[src[i]][PW-CW+EOMBIT];
      // Full uses registered occupancy only; a pop this cycle does not free a slot.
      full[i] = (count_q[i] == CNTW'(DEPTH));
      push[i] = found[i] & ~full[i] & ~reset;
      pop[i]  = (count_q[i] != '0) & umi.umi_out_ready[i];
      head[i] = mem_q[i][rd_ptr_q[i]];
    end
  end

  always_comb begin
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    lock_d     = lock_q;
    lock_src_d = lock_src_q;
    rr_d       = rr_q;
    mem_d      = mem_q;
    for (int i = 0; i < M; i++) begin
      if (push[i]) begin
        mem_d[i][wr_ptr_q[i]] = in_pkt[src[i]];
        wr_ptr_d[i] = wr_ptr_q[i] + 1'b1;
        if (eom[i]) begin
          lock_d[i] = 1'b0;
          // Pointer moves only at end of message so packets never interleave.
          rr_d[i]   = src[i];
        end else begin
          lock_d[i]     = 1'b1;
          lock_src_d[i] = src[i];
        end
      end
      if (pop[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
      end
      count_d[i] = count_q[i] + CNTW'(push[i]) - CNTW'(pop[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < M; i++) begin
        count_q[i]    <= '0;
        wr_ptr_q[i]   <= '0;
        rd_ptr_q[i]   <= '0;
        lock_src_q[i] <= '0;
        rr_q[i]       <= IW'(N-1);
      end
      lock_q <= '0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
      rr_q       <= rr_d;
    end
  end

  // Storage is not reset; contents are ignored while occupancy is zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    umi.umi_in_ready    = '0;
    umi.umi_out_valid   = '0;
    umi.umi_out_cmd     = '0;
    umi.umi_out_dstaddr = '0;
    umi.umi_out_srcaddr = '0;
    umi.umi_out_data    = '0;
    for (int i = 0; i < M; i++) begin
      if (push[i]) begin
        umi.umi_in_ready[src[i]] = 1'b1;
      end
      umi.umi_out_valid[i]            = (count_q[i] != '0);
      umi.umi_out_cmd[i*CW +: CW]     = head[i][PW-1 -: CW];
      umi.umi_out_dstaddr[i*AW +: AW] = head[i][DW+AW +: AW];
      umi.umi_out_srcaddr[i*AW +: AW] = head[i][DW +: AW];
      umi.umi_out_data[i*DW +: DW]    = head[i][DW-1:0];
    end
    umi.umi_out_lock = lock_q;
  end
endmodule

// File: tb/tb_umi_pkt_switch.sv
// Directed testbench for umi_pkt_switch (4x4, DEPTH 4, input 1 -> output 1
// statically disabled).
module tb_umi_pkt_switch;
  localparam int N = 4, M = 4, DW = 128, CW = 32, AW = 64, DEPTH = 4, EOMBIT = 22;
  localparam logic [M*N-1:0] MASK = 16'h0020;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [1:0]     arbmode;
  logic [N*M-1:0] arbmask;
  int             n_pass = 0;
  int             n_total = 0;

  umi_pkt_switch_if #(.N(N), .M(M), .DW(DW), .CW(CW), .AW(AW)) umi ();

  umi_pkt_switch #(.N(N), .M(M), .MASK(MASK), .DW(DW), .CW(CW), .AW(AW),
                   .DEPTH(DEPTH), .EOMBIT(EOMBIT)) dut (
    .clk(clk), .reset(reset), .arbmode(arbmode), .arbmask(arbmask), .umi(umi)
  );

  always #5 clk = ~clk;

  task automatic clr_in();
    umi.umi_in_valid   = '0;
    umi.umi_in_cmd     = '0;
    umi.umi_in_dstaddr = '0;
    umi.umi_in_srcaddr = '0;
    umi.umi_in_data    = '0;
  endtask

  task automatic set_in(input int j, input int i, input bit eom, input logic [31:0] tag);
    umi.umi_in_valid[i*N+j]         = 1'b1;
    umi.umi_in_cmd[j*CW +: CW]      = eom ? 32'h0040_0004 : 32'h0000_0004;
    umi.umi_in_dstaddr[j*AW +: AW]  = {32'h0000_D000, tag};
    umi.umi_in_srcaddr[j*AW +: AW]  = {32'h0000_5000, 32'(j)};
    umi.umi_in_data[j*DW +: DW]     = {96'h0, tag};
  endtask

  task automatic drop_in(input int j, input int i);
    umi.umi_in_valid[i*N+j] = 1'b0;
  endtask

  function automatic logic [31:0] out_tag(input int i);
    return umi.umi_out_data[i*DW +: 32];
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    clr_in();
    arbmask = '0;
    umi.umi_out_ready = '1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    arbmode = 2'd0;
    arbmask = '0;
    umi.umi_out_ready = '1;
    set_in(0, 0, 1'b1, 32'h11);
    @(negedge clk);
    n_total++; if (umi.umi_in_ready !== 4'b0000) $display("FAIL rst_ready: got %b want 0000", umi.umi_in_ready); else n_pass++;
    n_total++; if (umi.umi_out_valid !== 4'b0000) $display("FAIL rst_valid: got %b want 0000", umi.umi_out_valid); else n_pass++;
    n_total++; if (umi.umi_out_lock !== 4'b0000) $display("FAIL rst_lock: got %b want 0000", umi.umi_out_lock); else n_pass++;
    #1 reset = 1'b0;
    #1;
    n_total++; if (umi.umi_in_ready !== 4'b0001) $display("FAIL first_push_ready: got %b want 0001", umi.umi_in_ready); else n_pass++;
    @(posedge clk); #1;
    clr_in();
    @(negedge clk);
    n_total++; if (umi.umi_out_valid !== 4'b0001) $display("FAIL first_push_valid: got %b want 0001", umi.umi_out_valid); else n_pass++;
    n_total++; if (umi.umi_out_cmd[0 +: CW] !== 32'h0040_0004) $display("FAIL payload_cmd: got %h want 00400004", umi.umi_out_cmd[0 +: CW]); else n_pass++;
    n_total++; if (umi.umi_out_dstaddr[0 +: AW] !== 64'h0000_D000_0000_0011) $display("FAIL payload_dst: got %h want 0000d00000000011", umi.umi_out_dstaddr[0 +: AW]); else n_pass++;
    n_total++; if (umi.umi_out_srcaddr[0 +: AW] !== 64'h0000_5000_0000_0000) $display("FAIL payload_src: got %h want 0000500000000000", umi.umi_out_srcaddr[0 +: AW]); else n_pass++;
    n_total++; if (out_tag(0) !== 32'h11) $display("FAIL payload_data: got %h want 11", out_tag(0)); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++; if (umi.umi_out_valid !== 4'b0000) $display("FAIL drain_valid: got %b want 0000", umi.umi_out_valid); else n_pass++;
  endtask

  task automatic test_fixed();
    do_reset();
    arbmode = 2'd0;
    for (int c = 0; c < 6; c++) begin
      set_in(0, 1, 1'b1, 32'(c));
      set_in(2, 1, 1'b1, 32'(32'h200 + c));
      @(negedge clk);
      n_total++; if (umi.umi_in_ready !== 4'b0001) $display("FAIL fixed_ready c%0d: got %b want 0001", c, umi.umi_in_ready); else n_pass++;
      if (c > 0) begin
        n_total++; if (umi.umi_out_valid[1] !== 1'b1 || out_tag(1) !== 32'(c-1))
          $display("FAIL fixed_out c%0d: got v=%b %h want v=1 %h", c, umi.umi_out_valid[1], out_tag(1), c-1); else n_pass++;
      end
      @(posedge clk); #1;
    end
    clr_in();
    @(negedge clk);
    n_total++; if (out_tag(1) !== 32'h5) $display("FAIL fixed_last: got %h want 5", out_tag(1)); else n_pass++;
  endtask

  task automatic test_rr();
    int exp_win[5] = '{0, 1, 2, 3, 0};
    do_reset();
    arbmode = 2'd1;
    for (int j = 0; j < N; j++) set_in(j, 0, 1'b1, 32'(32'h100 + j));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_total++; if (umi.umi_in_ready !== 4'(1 << exp_win[c])) $display("FAIL rr_ready c%0d: got %b want %b", c, umi.umi_in_ready, 4'(1 << exp_win[c])); else n_pass++;
      if (c > 0) begin
        n_total++; if (umi.umi_out_valid[0] !== 1'b1 || out_tag(0) !== 32'(32'h100 + exp_win[c-1]))
          $display("FAIL rr_out c%0d: got v=%b %h want v=1 %h", c, umi.umi_out_valid[0], out_tag(0), 32'h100 + exp_win[c-1]); else n_pass++;
      end
      @(posedge clk); #1;
    end
    clr_in();
  endtask

  task automatic test_lock();
    logic [31:0] a_tag[3] = '{32'hA1, 32'hA2, 32'hA3};
    logic [3:0]  exp_rdy[5] = '{4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0000};
    logic        exp_lock[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] exp_out[5] = '{32'h0, 32'hA1, 32'hA2, 32'hA3, 32'hB0};
    do_reset();
    arbmode = 2'd1;
    for (int c = 0; c < 5; c++) begin
      if (c < 3) set_in(1, 2, c == 2, a_tag[c]); else drop_in(1, 2);
      if (c < 4) set_in(3, 2, 1'b1, 32'hB0); else drop_in(3, 2);
      @(negedge clk);
      n_total++; if (umi.umi_in_ready !== exp_rdy[c]) $display("FAIL lock_ready c%0d: got %b want %b", c, umi.umi_in_ready, exp_rdy[c]); else n_pass++;
      n_total++; if (umi.umi_out_lock[2] !== exp_lock[c]) $display("FAIL lock_flag c%0d: got %b want %b", c, umi.umi_out_lock[2], exp_lock[c]); else n_pass++;
      if (c > 0) begin
        n_total++; if (umi.umi_out_valid[2] !== 1'b1 || out_tag(2) !== exp_out[c])
          $display("FAIL lock_out c%0d: got v=%b %h want v=1 %h", c, umi.umi_out_valid[2], out_tag(2), exp_out[c]); else n_pass++;
      end
      @(posedge clk); #1;
    end
    clr_in();
  endtask

  task automatic test_lock_stall();
    logic [3:0] exp_rdy[5] = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b1000};
    do_reset();
    arbmode = 2'd0;
    for (int c = 0; c < 5; c++) begin
      if (c == 0) set_in(0, 2, 1'b0, 32'hC1);
      else if (c < 4) set_in(0, 2, 1'b1, 32'hC2);
      else drop_in(0, 2);
      set_in(3, 2, 1'b1, 32'hD0);
      arbmask = (c == 1 || c == 2) ? 16'h0100 : 16'h0000;
      @(negedge clk);
      n_total++; if (umi.umi_in_ready !== exp_rdy[c]) $display("FAIL stall_ready c%0d: got %b want %b", c, umi.umi_in_ready, exp_rdy[c]); else n_pass++;
      if (c == 1 || c == 2) begin
        n_total++; if (umi.umi_out_lock[2] !== 1'b1) $display("FAIL stall_lock c%0d: got %b want 1", c, umi.umi_out_lock[2]); else n_pass++;
      end
      if (c == 2) begin
        n_total++; if (umi.umi_out_valid[2] !== 1'b0) $display("FAIL stall_valid: got %b want 0", umi.umi_out_valid[2]); else n_pass++;
      end
      if (c == 4) begin
        n_total++; if (out_tag(2) !== 32'hC2) $display("FAIL stall_out: got %h want c2", out_tag(2)); else n_pass++;
      end
      @(posedge clk); #1;
    end
    clr_in();
    arbmask = '0;
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_data[14] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                  32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h0};
    logic        exp_rdy, exp_val;
    int          b = 0;
    do_reset();
    arbmode = 2'd0;
    for (int c = 0; c < 14; c++) begin
      umi.umi_out_ready[0] = (c >= 7);
      if (b < 6) set_in(0, 0, 1'b1, 32'(b)); else drop_in(0, 0);
      exp_rdy = (c <= 3) || (c == 8) || (c == 9);
      exp_val = (c >= 1) && (c <= 12);
      @(negedge clk);
      n_total++; if (umi.umi_in_ready[0] !== exp_rdy) $display("FAIL bp_ready c%0d: got %b want %b", c, umi.umi_in_ready[0], exp_rdy); else n_pass++;
      n_total++; if (umi.umi_out_valid[0] !== exp_val) $display("FAIL bp_valid c%0d: got %b want %b", c, umi.umi_out_valid[0], exp_val); else n_pass++;
      if (exp_val) begin
        n_total++; if (out_tag(0) !== exp_data[c]) $display("FAIL bp_data c%0d: got %h want %h", c, out_tag(0), exp_data[c]); else n_pass++;
      end
      if (umi.umi_in_ready[0] === 1'b1) b++;
      @(posedge clk); #1;
    end
    clr_in();
    umi.umi_out_ready = '1;
  endtask

  task automatic test_mask();
    do_reset();
    arbmode = 2'd0;
    set_in(1, 1, 1'b1, 32'h55);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_total++; if (umi.umi_in_ready[1] !== 1'b0) $display("FAIL mask_ready c%0d: got %b want 0", c, umi.umi_in_ready[1]); else n_pass++;
      n_total++; if (umi.umi_out_valid[1] !== 1'b0) $display("FAIL mask_valid c%0d: got %b want 0", c, umi.umi_out_valid[1]); else n_pass++;
      @(posedge clk); #1;
    end
    clr_in();
    set_in(2, 1, 1'b1, 32'h66);
    umi.umi_in_valid[3*N+2] = 1'b1;
    set_in(0, 1, 1'b1, 32'h44);
    arbmask = 16'h0010;
    @(negedge clk);
    n_total++; if (umi.umi_in_ready !== 4'b0100) $display("FAIL dynmask_ready: got %b want 0100", umi.umi_in_ready); else n_pass++;
    @(posedge clk); #1;
    arbmask = '0;
    @(negedge clk);
    n_total++; if (umi.umi_out_valid !== 4'b0010 || out_tag(1) !== 32'h66)
      $display("FAIL multi_target_out: got v=%b %h want v=0010 66", umi.umi_out_valid, out_tag(1)); else n_pass++;
    n_total++; if (umi.umi_in_ready !== 4'b0001) $display("FAIL unmask_ready: got %b want 0001", umi.umi_in_ready); else n_pass++;
    @(posedge clk); #1;
    clr_in();
  endtask

  task automatic test_parallel();
    do_reset();
    arbmode = 2'd1;
    set_in(0, 0, 1'b1, 32'h90);
    set_in(1, 2, 1'b1, 32'h91);
    set_in(3, 3, 1'b1, 32'h93);
    @(negedge clk);
    n_total++; if (umi.umi_in_ready !== 4'b1011) $display("FAIL par_ready: got %b want 1011", umi.umi_in_ready); else n_pass++;
    @(posedge clk); #1;
    clr_in();
    @(negedge clk);
    n_total++; if (umi.umi_out_valid !== 4'b1101) $display("FAIL par_valid: got %b want 1101", umi.umi_out_valid); else n_pass++;
    n_total++; if (out_tag(2) !== 32'h91 || out_tag(3) !== 32'h93)
      $display("FAIL par_data: got %h %h want 91 93", out_tag(2), out_tag(3)); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    arbmode = 2'd0;
    set_in(0, 3, 1'b0, 32'h71);
    @(negedge clk);
    n_total++; if (umi.umi_in_ready !== 4'b0001) $display("FAIL mid_ready: got %b want 0001", umi.umi_in_ready); else n_pass++;
    @(posedge clk); #1;
    set_in(0, 3, 1'b1, 32'h7F);
    @(negedge clk);
    n_total++; if (umi.umi_out_valid[3] !== 1'b1 || umi.umi_out_lock[3] !== 1'b1)
      $display("FAIL mid_locked: got v=%b l=%b want v=1 l=1", umi.umi_out_valid[3], umi.umi_out_lock[3]); else n_pass++;
    #1 reset = 1'b1;
    #1;
    n_total++; if (umi.umi_out_valid !== 4'b0000) $display("FAIL mid_rst_valid: got %b want 0000", umi.umi_out_valid); else n_pass++;
    n_total++; if (umi.umi_out_lock !== 4'b0000) $display("FAIL mid_rst_lock: got %b want 0000", umi.umi_out_lock); else n_pass++;
    n_total++; if (umi.umi_in_ready !== 4'b0000) $display("FAIL mid_rst_ready: got %b want 0000", umi.umi_in_ready); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    clr_in();
    set_in(2, 3, 1'b1, 32'h72);
    @(negedge clk);
    n_total++; if (umi.umi_in_ready !== 4'b0100) $display("FAIL post_rst_ready: got %b want 0100", umi.umi_in_ready); else n_pass++;
    @(posedge clk); #1;
    clr_in();
    @(negedge clk);
    n_total++; if (umi.umi_out_valid !== 4'b1000 || out_tag(3) !== 32'h72)
      $display("FAIL post_rst_out: got v=%b %h want v=1000 72", umi.umi_out_valid, out_tag(3)); else n_pass++;
  endtask

  initial begin
    clr_in();
    umi.umi_out_ready = '1;
    arbmode = 2'd0;
    arbmask = '0;
    test_reset();
    test_fixed();
    test_rr();
    test_lock();
    test_lock_stall();
    test_backpressure();
    test_mask();
    test_parallel();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
